branch_target_buffer: RTL and testbench
=======================================

BRANCH_TARGET_BUFFER -- requirements
Module: branch_target_buffer

Interface
REQ-001 The block SHALL have parameter ENTRIES, default 16, giving the number of direct-mapped entries (power of two, 4..64).
REQ-002 The block SHALL have parameter INDEX_W, default 4, equal to log2(ENTRIES).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port lookupPc, input, 32 bits: the current fetch PC to look up.
REQ-006 The block SHALL have port btbHit, output, 1 bit: high when lookupPc is predicted taken and has a known target.
REQ-007 The block SHALL have port btbPredictedPc, output, 32 bits: the predicted target, valid when btbHit is high.
REQ-008 The block SHALL have port updateEn, input, 1 bit: execute stage resolved a branch or jump this cycle.
REQ-009 The block SHALL have port updatePc, input, 32 bits: PC of the resolved branch.
REQ-010 The block SHALL have port updateTarget, input, 32 bits: resolved taken target.
REQ-011 The block SHALL have port updateTaken, input, 1 bit: the resolved direction, 1 = taken.
REQ-012 The block SHALL have port invalidateAll, input, 1 bit: clears every entry, used for fence.i or context change.

Function
REQ-013 Index SHALL be pc[INDEX_W+1:2] and tag SHALL be pc[31:INDEX_W+2]; pc[1:0] SHALL be ignored on both lookup and update.
REQ-014 Each entry SHALL hold valid (1 bit), tag (30-INDEX_W bits), target (32 bits) and ctr, a 2-bit saturating counter.
REQ-015 Lookup SHALL be purely combinational from registered state, with zero latency, so that fetch can consume it in the same cycle.
REQ-016 btbHit SHALL be valid[idx] AND tag match AND ctr[idx][1]=1.
REQ-017 btbPredictedPc SHALL be target[idx] when btbHit=1 and 32'd0 otherwise, with no X propagation.
REQ-018 An update SHALL take effect at the rising edge in which updateEn=1; there SHALL be no lookup bypass, so a write is visible to lookup from the next cycle.
REQ-019 On a taken update that matches (valid and tag equal), ctr SHALL saturating-increment (max 2'b11) and target SHALL be overwritten with updateTarget.
REQ-020 On a taken update that misses (invalid or tag differs), the block SHALL allocate: valid=1, tag=updatePc tag, target=updateTarget, ctr=2'b10, evicting any previous occupant unconditionally.
REQ-021 On a not-taken update that matches, ctr SHALL saturating-decrement (min 2'b00), with valid kept at 1 and target unchanged.
REQ-022 On a not-taken update that misses, the block SHALL make no state change; not-taken branches SHALL never allocate.
REQ-023 On invalidateAll=1, all valid bits SHALL clear at the next edge; invalidateAll SHALL win over a same-cycle updateEn, which is dropped.
REQ-024 A simultaneous lookup and update to the same index SHALL return the pre-update entry in that cycle.
REQ-025 Only one update per cycle SHALL be accepted; there is no buffering, and updateEn SHALL be honoured every cycle without backpressure.
REQ-026 When updateEn=0 the values on updatePc, updateTarget and updateTaken SHALL have no effect.

Reset
REQ-027 While rst=1 at a rising edge, every entry SHALL become valid=0, ctr=2'b00, tag=0, target=0, and any same-cycle update or invalidate SHALL be ignored.
REQ-028 From the cycle after reset, btbHit SHALL be 0 and btbPredictedPc SHALL be 32'd0 for every lookupPc until the first taken update.
REQ-029 Reset asserted mid-operation SHALL discard all trained state identically to reset at power-up.

Verification
REQ-030 Allocation and hit: after reset, a taken update with updatePc=0x00000040 and updateTarget=0x00000100; the next cycle lookupPc=0x40 -> btbHit=1 and btbPredictedPc=0x100; lookupPc=0x44 -> btbHit=0 and btbPredictedPc=0.
REQ-031 Hysteresis: after the taken allocation at 0x40 (ctr 10), one not-taken update -> ctr 01 and a lookup of 0x40 gives btbHit=0; one taken update -> ctr 10 and btbHit=1 again; three taken updates -> ctr saturates at 11, and one not-taken update -> still hit.
REQ-032 Aliasing: allocate 0x40->0x100, then a taken update 0x440->0x200 (same index, different tag) -> lookup 0x40 misses, lookup 0x440 hits with btbPredictedPc=0x200.
REQ-033 No allocation on not-taken: a not-taken update at 0x80 in an empty table -> lookup 0x80 gives btbHit=0 and the table is unchanged.
REQ-034 Priority: invalidateAll=1 together with a taken update 0xC0->0x300 -> next cycle every lookup misses, including 0xC0.
REQ-035 Same-cycle read/write and reset: allocate 0x40; in one cycle lookupPc=0x40 while a taken update 0x40->0x180 -> that cycle btbPredictedPc=0x100 and the next cycle 0x180; then rst=1 for one edge -> lookup 0x40 misses.

Source files
------------

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from registered state; updates land on the next rising edge.
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int INDEX_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookupPc,
    output logic        btbHit,
    output logic [31:0] btbPredictedPc,
    input  logic        updateEn,
    input  logic [31:0] updatePc,
    input  logic [31:0] updateTarget,
    input  logic        updateTaken,
    input  logic        invalidateAll
);

    localparam int TAG_W = 30 - INDEX_W;

    logic               valid_q  [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];

    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [INDEX_W-1:0] upd_idx;
    logic [TAG_W-1:0]   upd_tag;
    logic               upd_match;
    logic               unused_pc_bits;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Byte offset within the instruction word never takes part in index or tag.
    assign unused_pc_bits = ^{lookupPc[1:0], updatePc[1:0]};

    assign lk_idx  = lookupPc[INDEX_W+1:2];
    assign lk_tag  = lookupPc[31:INDEX_W+2];
    assign upd_idx = updatePc[INDEX_W+1:2];
    assign upd_tag = updatePc[31:INDEX_W+2];

    always_comb begin
        btbHit         = 1'b0;
        btbPredictedPc = 32'd0;
        upd_match      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        if (valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1]) begin
            btbHit         = 1'b1;
            btbPredictedPc = target_q[lk_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= 32'd0;
                ctr_q[i]    <= 2'b00;
            end
        end else if (invalidateAll) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (updateEn) begin
            if (updateTaken) begin
                if (upd_match) begin
                    ctr_q[upd_idx]    <= sat_inc(ctr_q[upd_idx]);
                    target_q[upd_idx] <= updateTarget;
                end else begin
                    // Taken miss evicts whatever lives at this index.
                    valid_q[upd_idx]  <= 1'b1;
                    tag_q[upd_idx]    <= upd_tag;
                    target_q[upd_idx] <= updateTarget;
                    ctr_q[upd_idx]    <= 2'b10;
                end
            end else if (upd_match) begin
                ctr_q[upd_idx] <= sat_dec(ctr_q[upd_idx]);
            end
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed vector table, then random traffic
// checked against a per-index reference model built from PC arithmetic.
module tb_branch_target_buffer;

    localparam int ENTRIES = 16;
    localparam int INDEX_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] lookupPc;
    logic        btbHit;
    logic [31:0] btbPredictedPc;
    logic        updateEn;
    logic [31:0] updatePc;
    logic [31:0] updateTarget;
    logic        updateTaken;
    logic        invalidateAll;

    branch_target_buffer #(.ENTRIES(ENTRIES), .INDEX_W(INDEX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .lookupPc      (lookupPc),
        .btbHit        (btbHit),
        .btbPredictedPc(btbPredictedPc),
        .updateEn      (updateEn),
        .updatePc      (updatePc),
        .updateTarget  (updateTarget),
        .updateTaken   (updateTaken),
        .invalidateAll (invalidateAll)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          inv;
        bit          en;
        bit          taken;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic [31:0] lpc;
        bit          chk;
        bit          hit;
        logic [31:0] pc;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: one record per index, counter kept as a plain integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];

    function automatic vec_t mk(bit r, bit inv, bit en, bit tk, logic [31:0] upc,
                                logic [31:0] utgt, logic [31:0] lpc, bit chk,
                                bit hit, logic [31:0] pc);
        vec_t v;
        v.rst = r; v.inv = inv; v.en = en; v.taken = tk; v.upc = upc; v.utgt = utgt;
        v.lpc = lpc; v.chk = chk; v.hit = hit; v.pc = pc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int midx(logic [31:0] pc);
        return int'((pc / 4) % ENTRIES);
    endfunction

    function automatic int unsigned mtag(logic [31:0] pc);
        return pc / (4 * ENTRIES);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
        end
    endtask

    task automatic model_step(bit r, bit inv, bit en, bit tk, logic [31:0] upc, logic [31:0] utgt);
        int  i;
        bit  match;
        if (r) begin
            model_clear();
        end else if (inv) begin
            for (int k = 0; k < ENTRIES; k++) m_valid[k] = 0;
        end else if (en) begin
            i     = midx(upc);
            match = m_valid[i] && (m_tag[i] == mtag(upc));
            if (tk) begin
                if (match) begin
                    m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
                    m_tgt[i] = utgt;
                end else begin
                    m_valid[i] = 1; m_tag[i] = mtag(upc); m_tgt[i] = utgt; m_ctr[i] = 2;
                end
            end else if (match) begin
                m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
        end
    endtask

    task automatic drive(bit r, bit inv, bit en, bit tk, logic [31:0] upc,
                         logic [31:0] utgt, logic [31:0] lpc);
        rst = r; invalidateAll = inv; updateEn = en; updateTaken = tk;
        updatePc = upc; updateTarget = utgt; lookupPc = lpc;
    endtask

    initial begin
        bit          r, inv, en, tk, ehit;
        logic [31:0] upc, utgt, lpc, epc;
        int          li;

        drive(1, 0, 0, 0, 0, 0, 0);

        // Directed scenarios: outputs are checked before the edge that applies the row's update.
        vecs.push_back(mk(1,0,0,0,32'h0,  32'h0,  32'h0,   0,0,32'h0));
        vecs.push_back(mk(0,0,1,1,32'h40, 32'h100,32'h40,  1,0,32'h0));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h40,  1,1,32'h100));
        vecs.push_back(mk(0,0,1,0,32'h40, 32'h0,  32'h44,  1,0,32'h0));
        vecs.push_back(mk(0,0,1,1,32'h40, 32'h100,32'h40,  1,0,32'h0));
        vecs.push_back(mk(0,0,1,1,32'h40, 32'h100,32'h40,  1,1,32'h100));
        vecs.push_back(mk(0,0,1,1,32'h40, 32'h100,32'h40,  1,1,32'h100));
        vecs.push_back(mk(0,0,1,1,32'h40, 32'h100,32'h40,  1,1,32'h100));
        vecs.push_back(mk(0,0,1,0,32'h40, 32'h0,  32'h40,  1,1,32'h100));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h40,  1,1,32'h100));
        vecs.push_back(mk(0,0,1,1,32'h440,32'h200,32'h40,  1,1,32'h100));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h40,  1,0,32'h0));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h440, 1,1,32'h200));
        vecs.push_back(mk(0,1,0,0,32'h0,  32'h0,  32'h440, 1,1,32'h200));
        vecs.push_back(mk(0,0,1,0,32'h80, 32'h0,  32'h440, 1,0,32'h0));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h80,  1,0,32'h0));
        vecs.push_back(mk(0,1,1,1,32'hC0, 32'h300,32'h80,  1,0,32'h0));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'hC0,  1,0,32'h0));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h440, 1,0,32'h0));
        vecs.push_back(mk(0,0,1,1,32'h40, 32'h100,32'h40,  1,0,32'h0));
        vecs.push_back(mk(0,0,1,1,32'h40, 32'h180,32'h40,  1,1,32'h100));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h40,  1,1,32'h180));
        vecs.push_back(mk(1,0,1,1,32'hC0, 32'h300,32'h40,  1,1,32'h180));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h40,  1,0,32'h0));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'hC0,  1,0,32'h0));
        vecs.push_back(mk(0,0,1,1,32'h103,32'h500,32'hC0,  1,0,32'h0));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h101, 1,1,32'h500));
        vecs.push_back(mk(0,0,0,1,32'h40, 32'h999,32'h102, 1,1,32'h500));
        vecs.push_back(mk(0,0,0,0,32'h0,  32'h0,  32'h40,  1,0,32'h0));

        for (int v = 0; v < vecs.size(); v++) begin
            @(negedge clk);
            drive(vecs[v].rst, vecs[v].inv, vecs[v].en, vecs[v].taken,
                  vecs[v].upc, vecs[v].utgt, vecs[v].lpc);
            #1;
            if (vecs[v].chk) begin
                check($sformatf("vec%0d_hit", v), {31'd0, btbHit}, {31'd0, vecs[v].hit});
                check($sformatf("vec%0d_pc", v), btbPredictedPc, vecs[v].pc);
            end
        end

        // Random traffic over a small tag pool so hits, aliasing and saturation all occur.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0);
        model_clear();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r    = ($urandom_range(0, 299) == 0);
            inv  = ($urandom_range(0, 79) == 0);
            en   = ($urandom_range(0, 3) != 0);
            tk   = ($urandom_range(0, 2) != 0);
            upc  = (32'($urandom_range(0, 2)) << (INDEX_W + 2)) |
                   (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
            utgt = $urandom;
            lpc  = (32'($urandom_range(0, 2)) << (INDEX_W + 2)) |
                   (32'($urandom_range(0, ENTRIES - 1)) << 2) | 32'($urandom_range(0, 3));
            if (c == 0) r = 0;
            drive(r, inv, en, tk, upc, utgt, lpc);
            li   = midx(lpc);
            ehit = m_valid[li] && (m_tag[li] == mtag(lpc)) && (m_ctr[li] >= 2);
            epc  = ehit ? m_tgt[li] : 32'd0;
            #1;
            check($sformatf("rnd%0d_hit", c), {31'd0, btbHit}, {31'd0, ehit});
            check($sformatf("rnd%0d_pc", c), btbPredictedPc, epc);
            model_step(r, inv, en, tk, upc, utgt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
